// File: rtl/qp_mem_arbiter.sv
// qp_mem_arbiter
// Shares the single-port query-patch SRAM between the kNN search engine
// (primary) and the Wishbone debug path (secondary, exclusive in debug mode).
// Grants are combinational. Read-valid flags are registered, so each read
// returns to the requester that issued it. A wait counter keeps Wishbone from
// starving, and a one-cycle SWITCH bubble drains the SRAM on every mode change.
module qp_mem_arbiter #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_WAIT   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wbs_mode,
    input  logic                             eng_req,
    input  logic                             eng_we,
    input  logic [ADDR_WIDTH-1:0]            eng_addr,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] eng_wdata,
    output logic                             eng_gnt,
    output logic                             eng_rvalid,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] eng_rdata,
    input  logic                             wbs_req,
    input  logic                             wbs_we,
    input  logic [ADDR_WIDTH-1:0]            wbs_addr,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_wdata,
    output logic                             wbs_gnt,
    output logic                             wbs_rvalid,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_rdata,
    output logic                             mem_csb0,
    output logic                             mem_web0,
    output logic [ADDR_WIDTH-1:0]            mem_addr0,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_wpatch0,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_rpatch0,
    output logic [CNT_WIDTH-1:0]             conflict_cnt
);

    localparam int PW = PATCH_SIZE * DATA_WIDTH;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_ENG    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_DBG    = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [WW-1:0]          wait_cnt_r;
    logic                   starve_s;
    logic                   eng_gnt_s;
    logic                   wbs_gnt_s;
    logic                   eng_rvalid_r;
    logic                   wbs_rvalid_r;
    logic [CNT_WIDTH-1:0]   conflict_cnt_r;
    logic                   mem_csb0_s;
    logic                   mem_web0_s;
    logic [ADDR_WIDTH-1:0]  mem_addr0_s;
    logic [PW-1:0]          mem_wpatch0_s;

    // Grant decision: engine first, Wishbone when engine idle or starved.
    // Gated by rst_n so grants drop immediately when reset is asserted.
    always_comb begin
        eng_gnt_s = 1'b0;
        wbs_gnt_s = 1'b0;
        starve_s  = (wait_cnt_r == WW'(MAX_WAIT));
        if (!rst_n) begin
            eng_gnt_s = 1'b0;
            wbs_gnt_s = 1'b0;
        end else begin
            case (state_r)
                ST_ENG: begin
                    eng_gnt_s = eng_req & ~starve_s;
                    wbs_gnt_s = wbs_req & (~eng_req | starve_s);
                end
                ST_DBG: begin
                    eng_gnt_s = 1'b0;
                    wbs_gnt_s = wbs_req;
                end
                ST_SWITCH: begin
                    eng_gnt_s = 1'b0;
                    wbs_gnt_s = 1'b0;
                end
                default: begin
                    eng_gnt_s = 1'b0;
                    wbs_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic: every mode change passes through one SWITCH cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ENG: begin
                if (wbs_mode) begin
                    state_next_s = ST_SWITCH;
                end else begin
                    state_next_s = ST_ENG;
                end
            end
            ST_DBG: begin
                if (!wbs_mode) begin
                    state_next_s = ST_SWITCH;
                end else begin
                    state_next_s = ST_DBG;
                end
            end
            ST_SWITCH: begin
                if (wbs_mode) begin
                    state_next_s = ST_DBG;
                end else begin
                    state_next_s = ST_ENG;
                end
            end
            default: begin
                state_next_s = ST_ENG;
            end
        endcase
    end

    // SRAM command mux: the granted requester drives the port, idle is all-quiet.
    always_comb begin
        mem_csb0_s    = ~(eng_gnt_s | wbs_gnt_s);
        mem_web0_s    = 1'b1;
        mem_addr0_s   = {ADDR_WIDTH{1'b0}};
        mem_wpatch0_s = {PW{1'b0}};
        if (eng_gnt_s) begin
            mem_web0_s    = ~eng_we;
            mem_addr0_s   = eng_addr;
            mem_wpatch0_s = eng_wdata;
        end else if (wbs_gnt_s) begin
            mem_web0_s    = ~wbs_we;
            mem_addr0_s   = wbs_addr;
            mem_wpatch0_s = wbs_wdata;
        end else begin
            mem_web0_s    = 1'b1;
            mem_addr0_s   = {ADDR_WIDTH{1'b0}};
            mem_wpatch0_s = {PW{1'b0}};
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ENG;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wishbone wait counter: counts denied cycles in ENG, saturating at MAX_WAIT.
    // Cleared on a Wishbone grant and whenever the arbiter is entering or in
    // a non-ENG state, so each normal-mode stretch starts with a fresh bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WW{1'b0}};
        end else if ((state_r != ST_ENG) || (state_next_s == ST_SWITCH)) begin
            wait_cnt_r <= {WW{1'b0}};
        end else if (wbs_gnt_s) begin
            wait_cnt_r <= {WW{1'b0}};
        end else if (wbs_req && (wait_cnt_r != WW'(MAX_WAIT))) begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Read-return ownership: flag the requester whose read was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_rvalid_r <= 1'b0;
            wbs_rvalid_r <= 1'b0;
        end else begin
            eng_rvalid_r <= eng_gnt_s & ~eng_we;
            wbs_rvalid_r <= wbs_gnt_s & ~wbs_we;
        end
    end

    // Saturating count of cycles where both requesters want the SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (eng_req && wbs_req && (conflict_cnt_r != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt_r <= conflict_cnt_r + CNT_WIDTH'(1);
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign eng_gnt      = eng_gnt_s;
    assign wbs_gnt      = wbs_gnt_s;
    assign eng_rvalid   = eng_rvalid_r;
    assign wbs_rvalid   = wbs_rvalid_r;
    assign eng_rdata    = mem_rpatch0;
    assign wbs_rdata    = mem_rpatch0;
    assign mem_csb0     = mem_csb0_s;
    assign mem_web0     = mem_web0_s;
    assign mem_addr0    = mem_addr0_s;
    assign mem_wpatch0  = mem_wpatch0_s;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: doc/qp_mem_arbiter.md
# qp_mem_arbiter

Shares the single-port query-patch SRAM between two requesters: the kNN search engine, which is the primary user, and the Wishbone debug path, which is the secondary user and exclusive owner in debug mode. Each requester uses a req/gnt handshake. The block drives the SRAM's active-low csb0/web0 port and routes the one-cycle-latency read data back to whichever requester issued the read. It also guarantees the Wishbone path cannot starve, and it inserts a drain bubble on every mode change.

## Interface
Parameters:
- DATA_WIDTH, 11, bits per patch element
- PATCH_SIZE, 5, elements per patch word
- ADDR_WIDTH, 9, SRAM address width; covers 24*17 = 408 query patches
- MAX_WAIT, 8, number of consecutive denied Wishbone cycles before Wishbone is force-granted
- CNT_WIDTH, 16, width of the conflict counter

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- wbs_mode  in  1  1 = debug mode (Wishbone owns the SRAM), 0 = normal mode
- eng_req  in  1  engine access request
- eng_we  in  1  1 = write, 0 = read
- eng_addr  in  ADDR_WIDTH  engine address
- eng_wdata  in  PATCH_SIZE*DATA_WIDTH  engine write patch
- eng_gnt  out  1  engine access accepted this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  PATCH_SIZE*DATA_WIDTH  engine read patch
- wbs_req, wbs_we, wbs_addr, wbs_wdata  in  same widths as the engine equivalents  Wishbone request fields
- wbs_gnt, wbs_rvalid  out  1  Wishbone grant and read-valid
- wbs_rdata  out  PATCH_SIZE*DATA_WIDTH  Wishbone read patch
- mem_csb0  out  1  SRAM chip select, active low
- mem_web0  out  1  SRAM write enable, active low
- mem_addr0  out  ADDR_WIDTH  SRAM address
- mem_wpatch0  out  PATCH_SIZE*DATA_WIDTH  SRAM write data
- mem_rpatch0  in  PATCH_SIZE*DATA_WIDTH  SRAM read data, valid one cycle after the read command
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with both requests asserted

## Operation
- States: ENG (normal), SWITCH (one-cycle bubble), DBG (debug).
- Transitions:
  - ENG → SWITCH when wbs_mode=1.
  - DBG → SWITCH when wbs_mode=0.
  - SWITCH → DBG if wbs_mode=1, else ENG.
  - SWITCH lasts exactly 1 cycle.
- Grant rules:
  - SWITCH: no grants.
  - DBG: wbs_gnt = wbs_req; eng_gnt = 0.
  - ENG:
    - Engine has priority: eng_gnt = eng_req, unless starve is set.
    - wbs_gnt = wbs_req & (~eng_req | starve).
    - starve = (wait_cnt == MAX_WAIT).
- wait_cnt:
  - Increments in ENG on each cycle with wbs_req & ~wbs_gnt, saturating at MAX_WAIT.
  - Clears on wbs_gnt.
  - Clears on entry to SWITCH.
- gnt is combinational in the same cycle as req. A requester holds req/we/addr/wdata stable until it samples gnt=1 at a rising edge. Each grant is exactly one access.
- SRAM drive:
  - Combinational from the granted requester: mem_csb0 = ~(eng_gnt | wbs_gnt); mem_web0 = ~we of the winner.
  - With no grant: mem_addr0 = 0, mem_wpatch0 = 0, mem_web0 = 1.
- Read return:
  - Registered owner flags: eng_rvalid <= eng_gnt & ~eng_we; wbs_rvalid <= wbs_gnt & ~wbs_we.
  - eng_rdata = wbs_rdata = mem_rpatch0, passed through. Data is valid only when the matching rvalid is high.
- conflict_cnt increments on every cycle with eng_req & wbs_req, in any state. It saturates at all-ones.
- Only one requester is granted in any given cycle.

## Timing
- Reset values: eng_gnt=0, wbs_gnt=0, eng_rvalid=0, wbs_rvalid=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0, conflict_cnt=0, state=ENG, wait_cnt=0.
- Read latency: grant in cycle N, rvalid high in cycle N+1 only. Back-to-back reads give rvalid on consecutive cycles.
- Writes: committed at the grant edge; no rvalid is produced.
- Mode change: the SWITCH bubble lets an in-flight read from cycle N return in SWITCH, routed to its original owner. No new grant is issued in SWITCH.
- Mode toggling 0→1→0 on consecutive cycles: ENG→SWITCH→ENG, with exactly one bubble.
- Starvation bound: with eng_req held high in ENG, a Wishbone request is granted no later than MAX_WAIT+1 cycles after wbs_req rises.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any pending rvalid is dropped.

## Test plan
- Reset: rst_n=0 with both reqs high → all gnt/rvalid 0, csb0=1, web0=1, conflict_cnt=0. Release reset, eng read of addr 5 → eng_gnt same cycle, csb0=0, web0=1, addr0=5. Drive rpatch=55'h00_1010_DEAD_BEEF → next cycle eng_rvalid=1 with that data; wbs_rvalid=0.
- Contention: ENG state, eng_req and wbs_req held high continuously → eng granted for 8 cycles, wbs granted on the 9th, then engine resumes. conflict_cnt increments by 9 over those cycles.
- Debug mode: assert wbs_mode → one SWITCH cycle with no grants. Then wbs write 0x0bcdef01234567 to addr 2 → csb0=0, web0=0, addr0=2, wpatch0 matches. eng_gnt stays 0 throughout.
- Drain: eng read granted in cycle N, wbs_mode rises in the same cycle → eng_rvalid=1 in N+1 (SWITCH); wbs_rvalid=0.
- Async reset mid-read: assert rst_n=0 between a grant and its return → rvalid never asserts, and state is ENG after release.
- Saturation: force both reqs high for 2^16+10 cycles → conflict_cnt=0xFFFF and holds.
